rand_range_sampler: RTL and testbench
=====================================

RAND_RANGE_SAMPLER -- requirements
Module: rand_range_sampler

Interface
REQ-001 SHALL have parameter W, default 10, meaning width of random input, bound and result.
REQ-002 SHALL have parameter MAX_TRIES, default 8, meaning draws attempted before fallback (1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rand_val  input  W  free-running LFSR output, new value every cycle.
REQ-006 SHALL have port bound  input  W  number of outcomes N for the request, sampled on acceptance.
REQ-007 SHALL have port req_valid  input  1  request for one sample.
REQ-008 SHALL have port req_ready  output  1  sampler can accept a request.
REQ-009 SHALL have port out_valid  output  1  out_data/out_fallback valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  W  sample in [0, N).
REQ-012 SHALL have port out_fallback  output  1  sample produced by fallback path.

Function
REQ-013 SHALL implement FSM IDLE, DRAW, HOLD; req_ready=1 only in IDLE, out_valid=1 only in HOLD.
REQ-014 SHALL in IDLE, on req_valid&&req_ready, latch bound (0 treated as 1), compute mask = smallest 2^k-1 >= N-1 (0 for N=1), clear try counter, go DRAW.
REQ-015 SHALL in DRAW each cycle form cand = rand_val & mask and increment try counter.
REQ-016 SHALL on cand < N latch out_data=cand, out_fallback=0, go HOLD.
REQ-017 SHALL on cand >= N at try MAX_TRIES latch out_data=cand-N, out_fallback=1, go HOLD; else stay DRAW.
REQ-018 SHALL give latency: accept at edge 0, first draw in cycle 1, out_valid asserted from edge 2 at best, edge MAX_TRIES+1 at worst.
REQ-019 SHALL hold out_data, out_fallback stable while out_valid && !out_ready.
REQ-020 SHALL on out_valid&&out_ready go IDLE; a new request is accepted no earlier than the following cycle.
REQ-021 SHALL ignore bound changes after acceptance; N=2^W-1 uses mask all-ones; N=1 always returns 0 on first draw.

Reset
REQ-022 SHALL on rst_n low asynchronously force IDLE, req_ready=1, out_valid=0, out_data=0, out_fallback=0, try counter 0.
REQ-023 SHALL on reset mid-DRAW or mid-HOLD discard the in-flight request without producing output.

Configuration
REQ-024 SHALL with RAND_SAMPLER_STATS_EN defined add output reject_cnt (16 bits), counting rejected draws, saturating at 0xFFFF, cleared only by reset.
REQ-025 SHALL without RAND_SAMPLER_STATS_EN omit reject_cnt port and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place FSM state encoding, default W and default MAX_TRIES in shared package rand_pkg.
REQ-027 SHALL implement mask derivation as combinational sub-module rand_mask_gen (bound in, mask out).

Verification
REQ-028 SHALL cover N=6, rand_val=0x003 in first DRAW cycle -> out_data=3, out_fallback=0, out_valid at edge 2.
REQ-029 SHALL cover N=6, rand_val=0x007,0x006,0x002 -> two rejects, out_data=2, out_valid at edge 4, reject_cnt=2 if enabled.
REQ-030 SHALL cover N=5, rand_val held 0x3FF for 8 draws -> out_data=2 (7-5), out_fallback=1, out_valid at edge 9.
REQ-031 SHALL cover out_ready low 5 cycles in HOLD -> out_data stable, req_ready=0 throughout, IDLE after handshake.
REQ-032 SHALL cover bound=0 and bound=1 -> out_data=0 on first draw; bound changed during DRAW has no effect.
REQ-033 SHALL cover rst_n pulsed low mid-DRAW -> out_valid never asserted, req_ready=1 in the first cycle after reset release.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the range sampler: default parameters, the width
// of the try counter and the FSM state encoding.
package rand_pkg;

    // Default width of random input, bound and result
    localparam int RAND_W_DEF         = 10;

    // Default number of draws attempted before the fallback path is used
    localparam int RAND_MAX_TRIES_DEF = 8;

    // Try counter is wide enough for MAX_TRIES up to 255
    localparam int TRY_W              = 8;

    // Sampler FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage : rand_pkg

// File: rtl/rand_mask_gen.sv
// Combinational mask derivation for the range sampler.
// Produces the smallest 2^k-1 that is >= bound-1 (0 when bound is 0 or 1),
// so that rand & mask covers [0, bound) with fewer than 2x extra outcomes.
module rand_mask_gen #(
    parameter int W = rand_pkg::RAND_W_DEF
) (
    input  logic [W-1:0] bound,
    output logic [W-1:0] mask
);

    // A zero bound behaves like a bound of one
    logic [W-1:0] w_n;
    logic [W-1:0] w_nm1;

    assign w_n   = (bound == '0) ? W'(1) : bound;
    assign w_nm1 = w_n - W'(1);

    // Bit gi of the mask is set when any bit at or above gi of N-1 is set,
    // i.e. N-1 smeared towards the LSB.
    for (genvar gi = 0; gi < W; gi++) begin : g_smear
        assign mask[gi] = |w_nm1[W-1:gi];
    end

endmodule : rand_mask_gen

// File: rtl/rand_range_sampler.sv
// Uniform sampler over [0, N) by masked rejection sampling on a free-running
// random source. Each draw is registered, then compared against N on the
// following edge; while a candidate is being judged the next one is already
// being captured, so draws proceed one per cycle.
// After MAX_TRIES rejected draws the last candidate is folded back into
// range (cand - N) and flagged via out_fallback.
// Optional build macro: RAND_SAMPLER_STATS_EN adds a saturating 16-bit
// reject_cnt output counting rejected draws.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int W         = RAND_W_DEF,
    parameter int MAX_TRIES = RAND_MAX_TRIES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] rand_val,
    input  logic [W-1:0] bound,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_fallback
`ifdef RAND_SAMPLER_STATS_EN
    ,
    output logic [15:0]  reject_cnt
`endif
);

    localparam logic [TRY_W-1:0] L_MAX_TRIES = TRY_W'(MAX_TRIES);

    // State and request context
    logic [1:0]       r_state;
    logic [W-1:0]     r_n;
    logic [W-1:0]     r_mask;
    logic [W-1:0]     r_cand;
    logic [TRY_W-1:0] r_try;
    logic [W-1:0]     r_out_data;
    logic             r_out_fb;

    // Combinational helpers
    logic [W-1:0]     w_bound_eff;
    logic [W-1:0]     w_mask;
    logic [W-1:0]     w_cand;
    logic             w_accept;
    logic             w_have_cand;
    logic             w_in_range;
    logic             w_last_try;
    logic             w_reject;

    // A zero bound is treated as one outcome
    assign w_bound_eff = (bound == '0) ? W'(1) : bound;

    rand_mask_gen #(
        .W (W)
    ) u_mask_gen (
        .bound (w_bound_eff),
        .mask  (w_mask)
    );

    assign req_ready    = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_HOLD);
    assign out_data     = r_out_data;
    assign out_fallback = r_out_fb;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_cand      = rand_val & r_mask;
    // r_try counts captured draws; zero means nothing to judge yet
    assign w_have_cand = (r_try != '0);
    assign w_in_range  = (r_cand < r_n);
    assign w_last_try  = (r_try == L_MAX_TRIES);
    assign w_reject    = (r_state == ST_DRAW) && w_have_cand && !w_in_range;

    // Main FSM: accept request, draw until a candidate lands in range or
    // the try budget is exhausted, then hold the result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_mask     <= '0;
            r_cand     <= '0;
            r_try      <= '0;
            r_out_data <= '0;
            r_out_fb   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_n     <= w_bound_eff;
                        r_mask  <= w_mask;
                        r_try   <= '0;
                        r_state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (w_have_cand && w_in_range) begin
                        r_out_data <= r_cand;
                        r_out_fb   <= 1'b0;
                        r_state    <= ST_HOLD;
                    end else if (w_have_cand && w_last_try) begin
                        // mask < 2N, so cand - N is always inside [0, N)
                        r_out_data <= r_cand - r_n;
                        r_out_fb   <= 1'b1;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_cand <= w_cand;
                        r_try  <= r_try + TRY_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] r_reject_cnt;

    assign reject_cnt = r_reject_cnt;

    // Count every judged-and-rejected draw, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reject_cnt <= '0;
        end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end
`else
    // Reject detection only feeds the optional statistics counter
    logic w_unused;
    assign w_unused = w_reject;
`endif

endmodule : rand_range_sampler

// File: tb/tb_rand_range_sampler.sv
// Directed self-checking bench for rand_range_sampler (W=10, MAX_TRIES=8).
// Edge 0 is the accepting edge; latencies are counted in rising edges after it.
`timescale 1ns/1ps
module tb_rand_range_sampler;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] rand_val;
    logic [W-1:0] bound;
    logic         req_valid;
    logic         req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_fallback;
`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0]  reject_cnt;
`endif

    int tests_run;
    int tests_failed;

    // Draw values: vals[k] is presented for draw k+1; last entry repeats
    logic [W-1:0] vals [0:15];
    int           nvals;

    rand_range_sampler #(
        .W         (W),
        .MAX_TRIES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rand_val     (rand_val),
        .bound        (bound),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_fallback (out_fallback)
`ifdef RAND_SAMPLER_STATS_EN
        ,
        .reject_cnt   (reject_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from a falling edge; return at the falling edge where
    // out_valid is first seen (lat = edges after acceptance, -1 on timeout).
    task automatic run_req(input logic [W-1:0] b, input logic [W-1:0] b_after,
                           output int lat);
        bit done;
        req_valid = 1'b1;
        bound     = b;
        rand_val  = vals[0];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        bound     = b_after;
        lat       = -1;
        done      = 1'b0;
        for (int e = 1; e <= 20 && !done; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat  = e;
                done = 1'b1;
            end else begin
                rand_val = vals[(e < nvals) ? e : nvals - 1];
            end
        end
    endtask

    // Complete the output handshake, returning at the next falling edge
    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (out_data !== 10'd0) begin tests_failed++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        tests_run++;
        if (out_fallback !== 1'b0) begin tests_failed++; $display("FAIL reset_out_fallback got=%b exp=0", out_fallback); end
`ifdef RAND_SAMPLER_STATS_EN
        tests_run++;
        if (reject_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_reject_cnt got=%0d exp=0", reject_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset: req_ready=%b out_valid=%b", req_ready, out_valid);
    endtask

    task automatic test_first_draw();
        int lat;
        vals[0] = 10'h003; nvals = 1;
        run_req(10'd6, 10'd6, lat);
        $display("[TB] first_draw N=6: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL first_draw_latency got=%0d exp=2", lat); end
        tests_run++;
        if (out_data !== 10'h003) begin tests_failed++; $display("FAIL first_draw_data got=%0h exp=3", out_data); end
        tests_run++;
        if (out_fallback !== 1'b0) begin tests_failed++; $display("FAIL first_draw_fallback got=%b exp=0", out_fallback); end
        handshake();
        tests_run++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL first_draw_idle got ready=%b valid=%b exp 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_rejects();
        int lat;
`ifdef RAND_SAMPLER_STATS_EN
        logic [15:0] cnt0;
        cnt0 = reject_cnt;
`endif
        vals[0] = 10'h007; vals[1] = 10'h006; vals[2] = 10'h002; nvals = 3;
        run_req(10'd6, 10'd6, lat);
        $display("[TB] rejects N=6: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL rejects_latency got=%0d exp=4", lat); end
        tests_run++;
        if (out_data !== 10'h002 || out_fallback !== 1'b0) begin
            tests_failed++; $display("FAIL rejects_data got=%0h/%b exp=2/0", out_data, out_fallback);
        end
`ifdef RAND_SAMPLER_STATS_EN
        tests_run++;
        if (reject_cnt !== cnt0 + 16'd2) begin tests_failed++; $display("FAIL rejects_cnt got=%0d exp=%0d", reject_cnt, cnt0 + 16'd2); end
`endif
        handshake();
    endtask

    task automatic test_fallback();
        int lat;
        vals[0] = 10'h3FF; nvals = 1;
        run_req(10'd5, 10'd5, lat);
        $display("[TB] fallback N=5: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("FAIL fallback_latency got=%0d exp=9", lat); end
        tests_run++;
        if (out_data !== 10'h002) begin tests_failed++; $display("FAIL fallback_data got=%0h exp=2", out_data); end
        tests_run++;
        if (out_fallback !== 1'b1) begin tests_failed++; $display("FAIL fallback_flag got=%b exp=1", out_fallback); end
        handshake();
    endtask

    task automatic test_hold_stall();
        int lat;
        vals[0] = 10'h005; nvals = 1;
        run_req(10'd6, 10'd6, lat);
        // Scramble the source so a non-held output would move
        rand_val = 10'h001;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || req_ready !== 1'b0 || out_data !== 10'h005) begin
                tests_failed++;
                $display("FAIL hold_stall_c%0d got valid=%b ready=%b data=%0h exp 1/0/5", c, out_valid, req_ready, out_data);
            end
            @(posedge clk);
            @(negedge clk);
        end
        handshake();
        $display("[TB] hold_stall: after handshake ready=%b valid=%b", req_ready, out_valid);
        tests_run++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL hold_stall_idle got ready=%b valid=%b exp 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_small_bounds();
        int lat;
        vals[0] = 10'h3FF; nvals = 1;
        run_req(10'd0, 10'd0, lat);
        $display("[TB] bound=0: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 2 || out_data !== 10'd0 || out_fallback !== 1'b0) begin
            tests_failed++; $display("FAIL bound0 got lat=%0d data=%0h fb=%b exp 2/0/0", lat, out_data, out_fallback);
        end
        handshake();
        run_req(10'd1, 10'd1, lat);
        $display("[TB] bound=1: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 2 || out_data !== 10'd0 || out_fallback !== 1'b0) begin
            tests_failed++; $display("FAIL bound1 got lat=%0d data=%0h fb=%b exp 2/0/0", lat, out_data, out_fallback);
        end
        handshake();
        // Bound drops to 1 right after acceptance; 5 must still be in range of N=6
        vals[0] = 10'h005; nvals = 1;
        run_req(10'd6, 10'd1, lat);
        $display("[TB] bound_change: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 2 || out_data !== 10'h005 || out_fallback !== 1'b0) begin
            tests_failed++; $display("FAIL bound_change got lat=%0d data=%0h fb=%b exp 2/5/0", lat, out_data, out_fallback);
        end
        handshake();
    endtask

    task automatic test_max_bound();
        int lat;
        vals[0] = 10'h3FE; nvals = 1;
        run_req(10'h3FF, 10'h3FF, lat);
        $display("[TB] max_bound a: lat=%0d data=%0h", lat, out_data);
        tests_run++;
        if (lat !== 2 || out_data !== 10'h3FE) begin
            tests_failed++; $display("FAIL max_bound_a got lat=%0d data=%0h exp 2/3fe", lat, out_data);
        end
        handshake();
        vals[0] = 10'h3FF; vals[1] = 10'h155; nvals = 2;
        run_req(10'h3FF, 10'h3FF, lat);
        $display("[TB] max_bound b: lat=%0d data=%0h", lat, out_data);
        tests_run++;
        if (lat !== 3 || out_data !== 10'h155) begin
            tests_failed++; $display("FAIL max_bound_b got lat=%0d data=%0h exp 3/155", lat, out_data);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        vals[0] = 10'h3FF; nvals = 1;
        run_req(10'd5, 10'd5, lat);
        handshake();
        // Try counter must restart: a good first draw finishes at edge 2
        vals[0] = 10'h004; nvals = 1;
        run_req(10'd6, 10'd6, lat);
        $display("[TB] back_to_back: lat=%0d data=%0h fb=%b", lat, out_data, out_fallback);
        tests_run++;
        if (lat !== 2 || out_data !== 10'h004 || out_fallback !== 1'b0) begin
            tests_failed++; $display("FAIL back_to_back got lat=%0d data=%0h fb=%b exp 2/4/0", lat, out_data, out_fallback);
        end
        handshake();
    endtask

    task automatic test_reset_mid_draw();
        bit saw_valid;
        req_valid = 1'b1;
        bound     = 10'd6;
        rand_val  = 10'h007;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_async got ready=%b valid=%b exp 1/0", req_ready, out_valid);
        end
        rand_val = 10'h002;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        saw_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        $display("[TB] reset_mid_draw: out_valid seen=%b", saw_valid);
        tests_run++;
        if (saw_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_output got=%b exp=0", saw_valid); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        rand_val     = '0;
        bound        = '0;
        req_valid    = 1'b0;
        out_ready    = 1'b0;
        nvals        = 1;
        for (int i = 0; i < 16; i++) vals[i] = '0;
        test_reset();
        test_first_draw();
        test_rejects();
        test_fallback();
        test_hold_stall();
        test_small_bounds();
        test_max_bound();
        test_back_to_back();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rand_range_sampler
